spi_slave_word: RTL and testbench
=================================

Name: spi_slave_word

Overview:
- SPI responder (slave) that forms the far end of the team's SPI master.
- Oversamples SCLK, CS_n and MOSI in the system clock domain and shifts words MSB first.
- Receives each word into RxData with a valid/ack handshake.
- Drives MISO from a single-entry transmit holding register with a ready/load handshake.
- Supports all four SPI modes via parameters.

Parameters:
- WordLen, 8, bits per word; legal range 2..32.
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- SCLK  input  1  SPI clock from master; asynchronous to clk.
- CS_n  input  1  chip select, active low; asynchronous.
- MOSI  input  1  serial data from master.
- MISO  output  1  serial data to master.
- MISOEn  output  1  MISO drive enable; 1 only while selected.
- TxData  input  WordLen  next word to transmit.
- TxLoad  input  1  write strobe for TxData.
- TxReady  output  1  holding register empty.
- TxUnderrun  output  1  one-cycle pulse: a word started with no data loaded.
- RxData  output  WordLen  last complete received word.
- RxValid  output  1  RxData holds an unacknowledged word.
- RxAck  input  1  consumer clears RxValid.
- RxOverrun  output  1  one-cycle pulse: a word completed while RxValid=1.

Behaviour:
- Reset values:
  - MISO=0, MISOEn=0, TxReady=1, TxUnderrun=0, RxData=0, RxValid=0, RxOverrun=0.
  - Shift registers, bit counter and holding register cleared; state IDLE.
- Reset is effective mid-transfer; the partial word is lost.
- Input synchronisation:
  - SCLK, CS_n and MOSI each pass through 2 flops; a third flop is used for edge detect.
  - Pin-to-internal-event latency is 3 clk cycles.
  - Requirement: SCLK high and low times each >= 4 clk periods.
  - Leading edge = SCLK transition away from CPOL; trailing edge = transition back to CPOL.
- FSM:
  - IDLE: MISOEn=0, bit count=0. Synchronised CS_n falling -> LOAD.
  - LOAD (1 cycle):
    - If TxReady=0, TxShift<=holding register and TxReady<=1.
    - If TxReady=1, TxShift<=0 and TxUnderrun pulses.
    - MISOEn<=1, MISO<=TxShift MSB. Next state ACTIVE.
  - ACTIVE, sample edge (leading if CPHA=0, trailing if CPHA=1):
    - RxShift<={RxShift[WordLen-2:0],MOSI_sync}; bit count +1.
  - ACTIVE, shift edge (the other edge):
    - TxShift shifts left and MISO<=new MSB.
    - For CPHA=1, the first leading edge outputs the loaded MSB without shifting.
  - ACTIVE, word complete (sample edge with bit count=WordLen-1):
    - Next cycle: RxData<=assembled word, RxValid<=1, bit count<=0.
    - If RxValid was already 1 and not being acked that cycle, RxOverrun pulses; RxData is still overwritten.
    - Then reload TxShift exactly as in LOAD; the first bit of the next word is presented on the next shift edge (CPHA=0) or leading edge (CPHA=1).
  - Any state, CS_n rising (synchronised) -> IDLE:
    - MISOEn<=0; partial word discarded with no RxValid and no overrun.
    - Bit count cleared; holding register and RxData retained.
- Tx handshake:
  - TxLoad with TxReady=1 captures TxData and sets TxReady<=0 on the next edge.
  - TxLoad with TxReady=0 is ignored.
  - If TxLoad coincides with a LOAD/reload that sees TxReady=1, the reload takes zeros (underrun) and TxLoad is captured for the following word.
- Rx handshake:
  - RxAck clears RxValid.
  - If RxAck and word completion coincide, RxValid stays 1 with the new data and there is no overrun.
- Bit counter width: $clog2(WordLen); wraps to 0 only at word completion.
- MOSI activity outside CS_n low has no effect.

Test Plan:
1. Mode 0, WordLen=8: load TxData=0xA5, master sends 0x3C with SCLK period 10 clk. Expect MISO bits 1,0,1,0,0,1,0,1; RxData=0x3C; one RxValid; TxReady=1 after LOAD.
2. Modes 1, 2 and 3, same words. Expect identical RxData=0x3C and MISO sequence 0xA5 on the correct edges; no extra leading-edge shift when CPHA=1.
3. Two back-to-back words without CS release, only the first word loaded. Expect the second word transmits 0x00, TxUnderrun pulses once at the second reload, and RxValid is set for both words.
4. Never RxAck during 2 words. Expect RxOverrun pulses once at the second completion and RxData equals the second word; in a separate run, RxAck on the completion cycle gives no overrun.
5. CS_n rises after 5 bits. Expect no RxValid, MISOEn=0 within 4 clk, and the next transfer is received correctly from bit 0.
6. Assert rst mid-word (bit 3). Expect all outputs at reset values immediately (asynchronously), and a clean full transfer after release.

Source files
------------

// File: rtl/spi_slave_word.sv
// spi_slave_word: oversampled SPI responder shifting words MSB first, with Rx valid/ack and Tx ready/load handshakes.
module spi_slave_word #(
  parameter int WordLen = 8,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SCLK,
  input  logic               CS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic               MISOEn,
  input  logic [WordLen-1:0] TxData,
  input  logic               TxLoad,
  output logic               TxReady,
  output logic               TxUnderrun,
  output logic [WordLen-1:0] RxData,
  output logic               RxValid,
  input  logic               RxAck,
  output logic               RxOverrun
);
  localparam int CW = $clog2(WordLen);
  localparam logic [CW-1:0] LAST = CW'(WordLen - 1);
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE, DONE} state_t;
  state_t state;
  logic [2:0] sclk_s, cs_s;
  logic [1:0] mosi_s;
  logic [WordLen-1:0] hold, tx_shift, rx_shift;
  logic [CW-1:0] cnt;
  logic fresh, und_p, lead, trail, smp, shf, cs_fall, cs_rise;
  assign lead = (sclk_s[1] != CPOL) && (sclk_s[2] == CPOL);
  assign trail = (sclk_s[1] == CPOL) && (sclk_s[2] != CPOL);
  assign smp = CPHA ? trail : lead;
  assign shf = CPHA ? lead : trail;
  assign cs_fall = !cs_s[1] && cs_s[2];
  assign cs_rise = cs_s[1] && !cs_s[2];
  // fresh: the next shift edge presents the freshly loaded MSB instead of shifting
  // und_p: an empty reload at word completion is flagged when the next word actually starts
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_s <= {3{CPOL}};
      cs_s <= 3'b111;
      mosi_s <= '0;
      state <= IDLE;
      hold <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      cnt <= '0;
      fresh <= 1'b0;
      und_p <= 1'b0;
      MISO <= 1'b0;
      MISOEn <= 1'b0;
      TxReady <= 1'b1;
      TxUnderrun <= 1'b0;
      RxData <= '0;
      RxValid <= 1'b0;
      RxOverrun <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[1:0], SCLK};
      cs_s <= {cs_s[1:0], CS_n};
      mosi_s <= {mosi_s[0], MOSI};
      TxUnderrun <= 1'b0;
      RxOverrun <= 1'b0;
      if (RxAck) RxValid <= 1'b0;
      if (TxLoad && TxReady) begin
        hold <= TxData;
        TxReady <= 1'b0;
      end
      if (cs_rise) begin
        state <= IDLE;
        MISOEn <= 1'b0;
        MISO <= 1'b0;
        cnt <= '0;
        und_p <= 1'b0;
      end else if (state == IDLE) begin
        if (cs_fall) state <= LOAD;
      end else if (state == LOAD || state == DONE) begin
        tx_shift <= TxReady ? '0 : hold;
        if (!TxReady) TxReady <= 1'b1;
        fresh <= CPHA || state == DONE;
        state <= ACTIVE;
        if (state == LOAD) begin
          MISOEn <= 1'b1;
          MISO <= !TxReady && hold[WordLen-1];
          TxUnderrun <= TxReady;
        end else begin
          RxData <= rx_shift;
          RxValid <= 1'b1;
          RxOverrun <= RxValid && !RxAck;
          cnt <= '0;
          und_p <= TxReady;
        end
      end else begin
        if (smp) begin
          rx_shift <= {rx_shift[WordLen-2:0], mosi_s[1]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        if (shf) begin
          tx_shift <= fresh ? tx_shift : tx_shift << 1;
          MISO <= fresh ? tx_shift[WordLen-1] : tx_shift[WordLen-2];
          fresh <= 1'b0;
        end
        if (lead && und_p) begin
          TxUnderrun <= 1'b1;
          und_p <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_spi_slave_word.sv
// tb_spi_slave_word: one responder per SPI mode, driven by a behavioural master and checked against a word-level model.
module tb_spi_slave_word;
  logic clk = 1'b0, rst = 1'b1, mosi = 1'b0;
  logic [3:0] sclk = 4'b1100, cs_n = 4'hf, tx_load = 4'h0, rx_ack = 4'h0;
  logic [7:0] tx_data = 8'h00;
  wire [3:0] miso, miso_en, tx_ready, tx_underrun, rx_valid, rx_overrun;
  wire [31:0] rx_data;
  int checks = 0, failures = 0, cyc = 0, ack_cyc = -1, und = 0, ovr = 0, md = 0;
  bit auto_ack = 1'b1;
  logic [7:0] mq[$], sq[$], rxq[$], pend[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_word #(.WordLen(8), .CPOL(g >= 2), .CPHA(g % 2 == 1)) u_dut (
      .clk(clk), .rst(rst), .SCLK(sclk[g]), .CS_n(cs_n[g]), .MOSI(mosi),
      .MISO(miso[g]), .MISOEn(miso_en[g]), .TxData(tx_data), .TxLoad(tx_load[g]),
      .TxReady(tx_ready[g]), .TxUnderrun(tx_underrun[g]), .RxData(rx_data[8*g+:8]),
      .RxValid(rx_valid[g]), .RxAck(rx_ack[g]), .RxOverrun(rx_overrun[g]));
  end

  // consumer side: counts pulses, optionally auto-acks and records delivered words
  always @(negedge clk) begin
    logic take;
    take = auto_ack && rx_valid[md] && !rx_ack[md];
    und += int'(tx_underrun[md]);
    ovr += int'(rx_overrun[md]);
    if (take) rxq.push_back(rx_data[8*md+:8]);
    rx_ack = (take || cyc == ack_cyc) ? 4'(1 << md) : 4'h0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (5) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] v);
    @(negedge clk);
    tx_data = v;
    tx_load[md] = 1'b1;
    @(negedge clk);
    tx_load = 4'h0;
    pend.push_back(v);
  endtask

  task automatic fill(input int n);
    mq.delete();
    repeat (n) mq.push_back(8'($urandom));
  endtask

  task automatic xfer(input int n, input int cut, input bit rcut, input bit coin);
    bit cpol, cpha;
    int total, k, b;
    logic [7:0] got;
    cpol = md >= 2;
    cpha = md % 2 == 1;
    total = cut > 0 ? cut : 8 * n;
    got = '0;
    sq.delete();
    @(negedge clk);
    cs_n[md] = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < total; i++) begin
      k = i / 8;
      b = 7 - i % 8;
      if (!cpha) begin
        mosi = mq[k][b];
        half();
        got[b] = miso[md];
        if (b == 7) chk("misoen", 32'(miso_en[md]), 1);
        sclk[md] = ~cpol;
        if (coin && i == total - 1) ack_cyc = cyc + 3;
        half();
        sclk[md] = cpol;
      end else begin
        sclk[md] = ~cpol;
        mosi = mq[k][b];
        half();
        got[b] = miso[md];
        if (b == 7) chk("misoen", 32'(miso_en[md]), 1);
        sclk[md] = cpol;
        if (coin && i == total - 1) ack_cyc = cyc + 3;
        half();
      end
      if (b == 0) sq.push_back(got);
    end
    if (rcut) begin
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_miso", 32'(miso[md]), 0);
      chk("rst_misoen", 32'(miso_en[md]), 0);
      chk("rst_txready", 32'(tx_ready[md]), 1);
      chk("rst_txund", 32'(tx_underrun[md]), 0);
      chk("rst_rxdata", 32'(rx_data[8*md+:8]), 0);
      chk("rst_rxvalid", 32'(rx_valid[md]), 0);
      chk("rst_rxovr", 32'(rx_overrun[md]), 0);
      @(negedge clk);
      cs_n[md] = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
    end else begin
      half();
      cs_n[md] = 1'b1;
      if (cut > 0) begin
        repeat (4) @(posedge clk);
        #1 chk("abort_misoen", 32'(miso_en[md]), 0);
      end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic txn(input string tag, input int n, input bit coin);
    int u0, o0, ue;
    logic [7:0] e;
    u0 = und;
    o0 = ovr;
    ue = 0;
    xfer(n, 0, 1'b0, coin);
    repeat (4) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      if (pend.size() > 0) e = pend.pop_front();
      else begin
        e = 8'h00;
        ue++;
      end
      chk($sformatf("m%0d_%s_miso%0d", md, tag, k), 32'(sq[k]), 32'(e));
    end
    chk($sformatf("m%0d_%s_und", md, tag), und - u0, ue);
    chk($sformatf("m%0d_%s_txready", md, tag), 32'(tx_ready[md]), 1);
    if (auto_ack) begin
      chk($sformatf("m%0d_%s_rxn", md, tag), rxq.size(), n);
      for (int k = 0; k < n && k < rxq.size(); k++)
        chk($sformatf("m%0d_%s_rx%0d", md, tag, k), 32'(rxq[k]), 32'(mq[k]));
      chk($sformatf("m%0d_%s_ovr", md, tag), ovr - o0, 0);
      rxq.delete();
    end else begin
      chk($sformatf("m%0d_%s_ovr", md, tag), ovr - o0, coin ? 0 : n - 1);
      chk($sformatf("m%0d_%s_rxvalid", md, tag), 32'(rx_valid[md]), 1);
      chk($sformatf("m%0d_%s_rxdata", md, tag), 32'(rx_data[8*md+:8]), 32'(mq[n-1]));
      auto_ack = 1'b1;
      repeat (3) @(negedge clk);
      rxq.delete();
      auto_ack = 1'b0;
      chk($sformatf("m%0d_%s_cleared", md, tag), 32'(rx_valid[md]), 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_txready", 32'(tx_ready), 32'hf);
    chk("reset_misoen", 32'(miso_en), 0);
    chk("reset_miso", 32'(miso), 0);
    chk("reset_rxvalid", 32'(rx_valid), 0);
    chk("reset_rxdata", rx_data, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      md = m;
      pend.delete();
      load(8'hA5);
      chk($sformatf("m%0d_loaded_txready", md), 32'(tx_ready[md]), 0);
      mq.delete();
      mq.push_back(8'h3C);
      txn("basic", 1, 1'b0);
      load(8'($urandom));
      fill(2);
      txn("b2b", 2, 1'b0);
      auto_ack = 1'b0;
      load(8'($urandom));
      fill(2);
      txn("ovr", 2, 1'b0);
      load(8'($urandom));
      fill(2);
      txn("coin", 2, 1'b1);
      auto_ack = 1'b1;
      load(8'($urandom));
      fill(1);
      xfer(1, 5, 1'b0, 1'b0);
      chk($sformatf("m%0d_abort_rxn", md), rxq.size(), 0);
      chk($sformatf("m%0d_abort_rxvalid", md), 32'(rx_valid[md]), 0);
      pend.delete();
      load(8'($urandom));
      fill(1);
      txn("post_abort", 1, 1'b0);
      load(8'($urandom));
      fill(1);
      xfer(1, 3, 1'b1, 1'b0);
      pend.delete();
      rxq.delete();
      load(8'($urandom));
      fill(1);
      txn("post_rst", 1, 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
